// File: rtl/pipe_field_engine_if.sv
// Control and display bundle between the game logic and the pipe field engine.
// master drives the game controls; slave (the engine) drives the pipe field.
interface pipe_field_engine_if #(
    parameter int N_PIPES = 3,
    parameter int X_W     = 17,
    parameter int Y_W     = 10,
    parameter int SCORE_W = 16
);
    logic                   start;
    logic                   pause;
    logic                   game_over;
    logic [N_PIPES*X_W-1:0] pipe_x;
    logic [N_PIPES*Y_W-1:0] pipe_y;
    logic [SCORE_W-1:0]     score;
    logic [1:0]             state;
    logic                   tick;

    modport master (
        output start, pause, game_over,
        input  pipe_x, pipe_y, score, state, tick
    );

    modport slave (
        input  start, pause, game_over,
        output pipe_x, pipe_y, score, state, tick
    );
endinterface

// File: rtl/pipe_field_engine.sv
// Scrolling pipe field: N pipes, LFSR gap heights, pass scoring, run/pause/over FSM.
// Optional speed ramp with score: define PIPE_FIELD_SPEED_RAMP_EN.
module pipe_field_engine #(
    parameter int          N_PIPES      = 3,
    parameter int          X_W          = 17,
    parameter int          Y_W          = 10,
    parameter int          SCORE_W      = 16,
    parameter int          SCREEN_W     = 640,
    parameter int          PIPE_W       = 52,
    parameter int          FIRST_X      = 161,
    parameter int          PIPE_SPACING = 213,
    parameter int          TICK_DIV     = 500000,
    parameter int          STEP         = 1,
    parameter int          GAP_Y_MIN    = 40,
    parameter int          GAP_Y_MAX    = 300,
    parameter int          BIRD_X       = 100,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          RAMP_EVERY   = 10,
    parameter int          STEP_MAX     = 4
) (
    input logic               clock,
    input logic               reset,
    pipe_field_engine_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int GAIN_W = $clog2(N_PIPES + 1);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic signed [X_W-1:0] X_WRAP    = X_W'(-PIPE_W);
    localparam logic signed [X_W-1:0] X_PW      = X_W'(PIPE_W);
    localparam logic signed [X_W-1:0] X_BIRD    = X_W'(BIRD_X);
    localparam logic signed [X_W-1:0] X_RESPAWN = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0]        Y_MIN     = Y_W'(GAP_Y_MIN);
    localparam logic [Y_W-1:0]        Y_RANGE   = Y_W'(GAP_Y_MAX - GAP_Y_MIN);

    function automatic logic signed [X_W-1:0] init_x(input int i);
        return X_W'(FIRST_X + i * PIPE_SPACING);
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic signed [X_W-1:0] x_q [N_PIPES];
    logic signed [X_W-1:0] x_d [N_PIPES];
    logic [Y_W-1:0]        y_q [N_PIPES];
    logic [Y_W-1:0]        y_d [N_PIPES];
    logic [SCORE_W-1:0]    score_q, score_d;
    logic                  tick_q, tick_d;

    logic signed [X_W-1:0] step_w;
    logic signed [X_W-1:0] xn [N_PIPES];
    logic                  wrap [N_PIPES];
    logic [15:0]           lfsr_sh [N_PIPES];
    logic [Y_W-1:0]        r [N_PIPES];
    logic [Y_W-1:0]        respawn_y [N_PIPES];
    logic [GAIN_W-1:0]     gain;
    logic [SCORE_W:0]      score_sum;
    logic [SCORE_W-1:0]    score_step;

`ifdef PIPE_FIELD_SPEED_RAMP_EN
    localparam int PTS_W = $clog2(RAMP_EVERY + N_PIPES + 1);
    localparam logic [PTS_W-1:0]      PTS_EVERY  = PTS_W'(RAMP_EVERY);
    localparam logic signed [X_W-1:0] X_STEP     = X_W'(STEP);
    localparam logic signed [X_W-1:0] X_STEP_MAX = X_W'(STEP_MAX);

    logic signed [X_W-1:0] step_q, step_d;
    logic [PTS_W-1:0]      pts_q, pts_d, pts_sum;

    assign step_w  = step_q;
    assign pts_sum = pts_q + PTS_W'(gain);

    always_comb begin
        step_d = step_q;
        pts_d  = pts_q;
        if (state_q == OVER && bus.start) begin
            step_d = X_STEP;
            pts_d  = '0;
        end else if (state_q == RUN && !bus.game_over &&
                     !bus.pause && cnt_q == CNT_LAST) begin
            // Points carry past the threshold; the new step applies next tick.
            if (pts_sum >= PTS_EVERY) begin
                pts_d = pts_sum - PTS_EVERY;
                if (step_q < X_STEP_MAX) step_d = step_q + X_W'(1);
            end else begin
                pts_d = pts_sum;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_q <= X_STEP;
            pts_q  <= '0;
        end else begin
            step_q <= step_d;
            pts_q  <= pts_d;
        end
    end
`else
    logic unused_ramp;
    assign unused_ramp = ^{RAMP_EVERY, STEP_MAX};
    assign step_w      = X_W'(STEP);
`endif

    always_comb begin
        gain = '0;
        for (int i = 0; i < N_PIPES; i++) begin
            xn[i]      = x_q[i] - step_w;
            wrap[i]    = xn[i] < X_WRAP;
            lfsr_sh[i] = lfsr_q >> i;
            r[i]       = {1'b0, lfsr_sh[i][Y_W-2:0]};
            // Fold values above the range back into it instead of clamping.
            respawn_y[i] = Y_MIN + ((r[i] > Y_RANGE) ?
                           (r[i] - Y_RANGE - Y_W'(1)) : r[i]);
            if ((x_q[i] + X_PW >= X_BIRD) && (xn[i] + X_PW < X_BIRD))
                gain = gain + GAIN_W'(1);
        end
        score_sum  = {1'b0, score_q} + (SCORE_W+1)'(gain);
        score_step = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        tick_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.game_over) begin
                    state_d = OVER;
                end else if (!bus.pause) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        tick_d  = 1'b1;
                        score_d = score_step;
                        for (int i = 0; i < N_PIPES; i++) begin
                            x_d[i] = wrap[i] ? X_RESPAWN : xn[i];
                            if (wrap[i]) y_d[i] = respawn_y[i];
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            OVER: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    score_d = '0;
                    for (int i = 0; i < N_PIPES; i++) begin
                        x_d[i] = init_x(i);
                        y_d[i] = Y_MIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            score_q <= '0;
            tick_q  <= 1'b0;
            for (int i = 0; i < N_PIPES; i++) begin
                x_q[i] <= init_x(i);
                y_q[i] <= Y_MIN;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            score_q <= score_d;
            tick_q  <= tick_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    logic [N_PIPES*X_W-1:0] px;
    logic [N_PIPES*Y_W-1:0] py;

    always_comb begin
        px = '0;
        py = '0;
        for (int i = 0; i < N_PIPES; i++) begin
            px[i*X_W +: X_W] = x_q[i];
            py[i*Y_W +: Y_W] = y_q[i];
        end
    end

    assign bus.pipe_x = px;
    assign bus.pipe_y = py;
    assign bus.score  = score_q;
    assign bus.state  = state_q;
    assign bus.tick   = tick_q;
endmodule

// File: tb/tb_pipe_field_engine.sv
// Directed bench for pipe_field_engine with a fast tick (TICK_DIV=4).
// Expected values are hand-derived from the default geometry.
module tb_pipe_field_engine;
    localparam int TD = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipe_field_engine_if #(
        .N_PIPES(3), .X_W(17), .Y_W(10), .SCORE_W(16)
    ) bus ();

    pipe_field_engine #(.TICK_DIV(TD)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] px(input int i);
        logic [16:0] v;
        v = bus.pipe_x[i*17 +: 17];
        return {{15{v[16]}}, v};
    endfunction

    function automatic logic signed [31:0] py(input int i);
        logic [9:0] v;
        v = bus.pipe_y[i*10 +: 10];
        return {22'b0, v};
    endfunction

    // Spec LFSR: 16-bit Fibonacci, taps 16,14,13,11.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0],
                       m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    function automatic logic signed [31:0] exp_y(input logic [15:0] l);
        int rr;
        rr = int'(l[8:0]);
        return 40 + ((rr > 260) ? rr - 261 : rr);
    endfunction

    task automatic clk(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic run_ticks(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = n * TD + 8;
        while (seen < n && budget > 0) begin
            clk();
            budget--;
            if (bus.tick === 1'b1) seen++;
        end
        if (seen < n) chk("tick_timeout", seen, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pticks;
        int in_rng;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.game_over = 1'b0;
        clk(2);
        chk("rst_x0", px(0), 161);
        chk("rst_x1", px(1), 374);
        chk("rst_x2", px(2), 587);
        chk("rst_y0", py(0), 40);
        chk("rst_y1", py(1), 40);
        chk("rst_y2", py(2), 40);
        chk("rst_score", bus.score, 0);
        chk("rst_state", bus.state, 0);
        chk("rst_tick", bus.tick, 0);

        reset = 1'b0;
        clk(3);
        chk("idle_x0", px(0), 161);
        chk("idle_state", bus.state, 0);

        bus.start = 1'b1;
        clk();
        bus.start = 1'b0;
        chk("run_state", bus.state, 1);
        clk(3);
        chk("pre_tick", bus.tick, 0);
        chk("pre_x0", px(0), 161);
        clk();
        chk("tick1", bus.tick, 1);
        chk("tick1_x0", px(0), 160);
        clk();
        chk("tick_width", bus.tick, 0);
        clk(2);
        chk("tick_gap", bus.tick, 0);
        clk();
        chk("tick2", bus.tick, 1);
        chk("tick2_x0", px(0), 159);

        run_ticks(111);
        chk("pre_pass_x0", px(0), 48);
        chk("pre_pass_score", bus.score, 0);
        run_ticks(1);
        chk("pass_x0", px(0), 47);
        chk("pass_score", bus.score, 1);
        run_ticks(1);
        chk("post_pass_score", bus.score, 1);

        clk(2);
        bus.pause = 1'b1;
        pticks = 0;
        for (int k = 0; k < 10; k++) begin
            clk();
            if (bus.tick === 1'b1) pticks++;
        end
        chk("pause_ticks", pticks, 0);
        chk("pause_x0", px(0), 46);
        bus.pause = 1'b0;
        clk();
        chk("resume_early", bus.tick, 0);
        clk();
        chk("resume_tick", bus.tick, 1);
        chk("resume_x0", px(0), 45);

        run_ticks(97);
        chk("edge_x0", px(0), -52);
        run_ticks(1);
        chk("wrap_x0", px(0), 640);
        chk("wrap_tick", bus.tick, 1);
        chk("wrap_y0", py(0), exp_y(m_prev));
        in_rng = (py(0) >= 40 && py(0) <= 300) ? 1 : 0;
        chk("wrap_y0_range", in_rng, 1);
        chk("wrap_x1", px(1), 160);
        chk("wrap_x2", px(2), 373);
        chk("wrap_score", bus.score, 1);

        clk(3);
        bus.game_over = 1'b1;
        clk();
        bus.game_over = 1'b0;
        chk("over_state", bus.state, 2);
        chk("over_tick", bus.tick, 0);
        chk("over_x0", px(0), 640);
        chk("over_x1", px(1), 160);
        chk("over_score", bus.score, 1);
        clk(8);
        chk("frozen_x1", px(1), 160);
        chk("frozen_state", bus.state, 2);

        bus.start = 1'b1;
        clk();
        bus.start = 1'b0;
        chk("restart_state", bus.state, 1);
        chk("restart_x0", px(0), 161);
        chk("restart_x1", px(1), 374);
        chk("restart_x2", px(2), 587);
        chk("restart_y0", py(0), 40);
        chk("restart_score", bus.score, 0);
        clk(3);
        chk("restart_pre", bus.tick, 0);
        clk();
        chk("restart_tick", bus.tick, 1);
        chk("restart_tick_x0", px(0), 160);

        bus.start = 1'b1;
        clk();
        bus.start = 1'b0;
        chk("start_in_run", bus.state, 1);

        clk(5);
        reset = 1'b1;
        #2;
        chk("async_rst_x0", px(0), 161);
        chk("async_rst_state", bus.state, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
